// File: rtl/forest_pkg.sv
// forest_pkg: shared FSM encoding, node-word field layout and width helpers
package forest_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_NODE_RD,
    S_NODE_DEC,
    S_FEAT_CMP,
    S_NEXT_TREE,
    S_MAJ,
    S_DONE
  } state_t;
  localparam int THR_W  = 8;
  localparam int VOTE_W = 8;
  function automatic int thr_lo(input int naw);
    return naw;
  endfunction
  function automatic int feat_lo(input int naw);
    return naw + THR_W;
  endfunction
  function automatic int leaf_bit(input int faw, input int naw);
    return naw + THR_W + faw;
  endfunction
  function automatic int cls_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/forest_eval_sequencer_vote_tally.sv
// vote_tally: saturating per-class vote counters and a one-class-per-cycle argmax scanner
module vote_tally
  import forest_pkg::*;
#(
  parameter int NUM_CLASSES = 4,
  parameter int CLASS_W     = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_clr,
  input  logic                          i_inc,
  input  logic [CLASS_W-1:0]            i_cls,
  input  logic                          i_scan,
  output logic                          o_scan_last,
  output logic [CLASS_W-1:0]            o_best,
  output logic [VOTE_W-1:0]             o_best_votes,
  output logic [NUM_CLASSES*VOTE_W-1:0] o_counts
);
  localparam int IW = cls_w(NUM_CLASSES);
  logic [VOTE_W-1:0] r_cnt [NUM_CLASSES];
  logic [IW-1:0]     r_idx;
  logic [VOTE_W-1:0] w_cur;

  assign w_cur       = r_cnt[r_idx];
  assign o_scan_last = r_idx == IW'(NUM_CLASSES - 1);

  for (genvar c = 0; c < NUM_CLASSES; c++) begin : g_pack
    assign o_counts[c*VOTE_W +: VOTE_W] = r_cnt[c];
  end

  // Counters: an out-of-range class matches no counter and is dropped; full counters stick at max
  always_ff @(posedge clk or posedge rst)
    if (rst || i_clr) r_cnt <= '{default: '0};
    else if (i_inc)
      for (int k = 0; k < NUM_CLASSES; k++)
        if (i_cls == CLASS_W'(k) && r_cnt[k] != '1) r_cnt[k] <= r_cnt[k] + 1'b1;

  // Scanner: strict greater-than keeps the lowest index on ties and leaves class 0 / 0 votes when empty
  always_ff @(posedge clk or posedge rst)
    if (rst || i_clr) begin
      r_idx        <= '0;
      o_best       <= '0;
      o_best_votes <= '0;
    end else if (i_scan) begin
      if (w_cur > o_best_votes) begin
        o_best       <= CLASS_W'(r_idx);
        o_best_votes <= w_cur;
      end
      r_idx <= o_scan_last ? '0 : r_idx + 1'b1;
    end
endmodule

// File: rtl/forest_eval_sequencer.sv
// forest_eval_sequencer: walks each tree node by node, tallies leaf votes and reports the majority
// class; define FOREST_EVAL_HIST_EN to add the vote_hist snapshot output.
module forest_eval_sequencer
  import forest_pkg::*;
#(
  parameter int NUM_TREES   = 8,
  parameter int NUM_CLASSES = 4,
  parameter int CLASS_W     = 4,
  parameter int NODE_AW     = 12,
  parameter int FEAT_AW     = 14,
  parameter int TREE_SHIFT  = 8,
  parameter int MAX_DEPTH   = 15
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  output logic [NODE_AW-1:0]          node_rd_addr,
  input  logic [FEAT_AW+NODE_AW+8:0]  node_rd_data,
  output logic [FEAT_AW-1:0]          feat_rd_addr,
  input  logic [7:0]                  feat_rd_data,
  output logic                        busy,
  output logic                        done,
  output logic [CLASS_W-1:0]          result,
  output logic [7:0]                  result_votes,
  output logic                        depth_err
`ifdef FOREST_EVAL_HIST_EN
  ,
  output logic [NUM_CLASSES*8-1:0]    vote_hist
`endif
);
  localparam int FLO  = feat_lo(NODE_AW);
  localparam int LEAF = leaf_bit(FEAT_AW, NODE_AW);
  state_t             r_state;
  logic [7:0]         r_tree;
  logic [7:0]         r_depth;
  logic [7:0]         r_thr;
  logic [NODE_AW-1:0] r_child;
  logic               w_leaf;
  logic [FEAT_AW-1:0] w_feat;
  logic [7:0]         w_thr;
  logic [NODE_AW-1:0] w_child;
  logic [NODE_AW-1:0] w_next;
  logic [NODE_AW-1:0] w_root;
  logic [7:0]         w_depth_nx;
  logic               w_abort;
  logic               w_scan_last;
  logic [CLASS_W-1:0] w_best;
  logic [7:0]         w_best_votes;
`ifdef FOREST_EVAL_HIST_EN
  logic [NUM_CLASSES*8-1:0] w_counts;
`endif

  assign w_leaf     = node_rd_data[LEAF];
  assign w_feat     = node_rd_data[LEAF-1:FLO];
  assign w_thr      = node_rd_data[FLO-1:thr_lo(NODE_AW)];
  assign w_child    = node_rd_data[NODE_AW-1:0];
  assign w_next     = (feat_rd_data <= r_thr) ? r_child : r_child + 1'b1;
  assign w_root     = NODE_AW'(r_tree + 8'd1) << TREE_SHIFT;
  assign w_depth_nx = r_depth + 1'b1;
  assign w_abort    = w_depth_nx == 8'(MAX_DEPTH);

  vote_tally #(
    .NUM_CLASSES(NUM_CLASSES),
    .CLASS_W    (CLASS_W)
  ) u_tally (
    .clk         (clk),
    .rst         (rst),
    .i_clr       (r_state == S_IDLE && start),
    .i_inc       (r_state == S_NODE_DEC && w_leaf),
    .i_cls       (w_child[CLASS_W-1:0]),
    .i_scan      (r_state == S_MAJ),
    .o_scan_last (w_scan_last),
    .o_best      (w_best),
    .o_best_votes(w_best_votes),
`ifdef FOREST_EVAL_HIST_EN
    .o_counts    (w_counts)
`else
    .o_counts    ()
`endif
  );

  // Sequencer: the address registers feed the RAMs directly, so the word for an address is
  // presented in the cycle after that address is loaded
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state      <= S_IDLE;
      node_rd_addr <= '0;
      feat_rd_addr <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      result       <= '0;
      result_votes <= '0;
      depth_err    <= 1'b0;
      r_tree       <= '0;
      r_depth      <= '0;
      r_thr        <= '0;
      r_child      <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE:
          if (start) begin
            r_tree       <= '0;
            node_rd_addr <= '0;
            r_depth      <= '0;
            depth_err    <= 1'b0;
            busy         <= 1'b1;
            r_state      <= S_NODE_RD;
          end
        S_NODE_RD: r_state <= S_NODE_DEC;
        S_NODE_DEC:
          if (w_leaf) r_state <= S_NEXT_TREE;
          else begin
            r_thr        <= w_thr;
            r_child      <= w_child;
            feat_rd_addr <= w_feat;
            r_state      <= S_FEAT_CMP;
          end
        S_FEAT_CMP: begin
          node_rd_addr <= w_next;
          r_depth      <= w_depth_nx;
          depth_err    <= depth_err | w_abort;
          r_state      <= w_abort ? S_NEXT_TREE : S_NODE_RD;
        end
        S_NEXT_TREE:
          if (r_tree == 8'(NUM_TREES - 1)) r_state <= S_MAJ;
          else begin
            r_tree       <= r_tree + 1'b1;
            node_rd_addr <= w_root;
            r_depth      <= '0;
            r_state      <= S_NODE_RD;
          end
        S_MAJ: r_state <= w_scan_last ? S_DONE : S_MAJ;
        S_DONE: begin
          result       <= w_best;
          result_votes <= w_best_votes;
          done         <= 1'b1;
          busy         <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end

`ifdef FOREST_EVAL_HIST_EN
  // Histogram snapshot taken alongside the result so both stay coherent until the next done
  always_ff @(posedge clk or posedge rst)
    if (rst) vote_hist <= '0;
    else if (r_state == S_DONE) vote_hist <= w_counts;
`endif
endmodule

// File: tb/tb_forest_eval_sequencer.sv
// tb_forest_eval_sequencer: directed forests checked cycle by cycle against a forest-walking model
`timescale 1ns/1ps
module tb_forest_eval_sequencer;
  localparam int NT = 4, NC = 4, CW = 4, NAW = 12, FAW = 14, TS = 8, MD = 15;
  localparam int NW = 1 + FAW + 8 + NAW;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [NAW-1:0] node_rd_addr;
  logic [NW-1:0]  node_rd_data;
  logic [FAW-1:0] feat_rd_addr;
  logic [7:0]     feat_rd_data;
  logic           busy, done, depth_err;
  logic [CW-1:0]  result;
  logic [7:0]     result_votes;
`ifdef FOREST_EVAL_HIST_EN
  logic [NC*8-1:0] vote_hist;
`endif
  logic [NW-1:0] node_mem [1<<NAW];
  logic [7:0]    feat_mem [1<<FAW];
  int checks = 0, failures = 0;
  int cyc = 0, done_cyc = -1, probe_cyc = -1, probe_exp = 0;
  bit active = 1'b0;
  int exp_res, exp_votes, exp_err, exp_lat;
  logic [NC*8-1:0] exp_hist;

  always #5 clk = ~clk;
  // The sequencer's address outputs are the RAM address registers; data follows them
  assign node_rd_data = node_mem[node_rd_addr];
  assign feat_rd_data = feat_mem[feat_rd_addr];

  forest_eval_sequencer #(
    .NUM_TREES(NT), .NUM_CLASSES(NC), .CLASS_W(CW), .NODE_AW(NAW),
    .FEAT_AW(FAW), .TREE_SHIFT(TS), .MAX_DEPTH(MD)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .node_rd_addr(node_rd_addr), .node_rd_data(node_rd_data),
    .feat_rd_addr(feat_rd_addr), .feat_rd_data(feat_rd_data),
    .busy(busy), .done(done), .result(result), .result_votes(result_votes),
    .depth_err(depth_err)
`ifdef FOREST_EVAL_HIST_EN
    , .vote_hist(vote_hist)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic put_leaf(input int a, input int c);
    node_mem[a] = {1'b1, FAW'(0), 8'd0, NAW'(c)};
  endtask

  task automatic put_int(input int a, input int f, input int thr, input int ch);
    node_mem[a] = {1'b0, FAW'(f), 8'(thr), NAW'(ch)};
  endtask

  task automatic roots(input int c0, input int c1, input int c2, input int c3);
    put_leaf(0 << TS, c0);
    put_leaf(1 << TS, c1);
    put_leaf(2 << TS, c2);
    put_leaf(3 << TS, c3);
  endtask

  // Walk every tree from the memory images, counting cycles with the published per-step costs
  task automatic model();
    int votes [NC];
    int lat, a, d, c, fidx, thr, ch;
    logic [NW-1:0] w;
    votes = '{default: 0};
    lat = 1;
    exp_err = 0;
    for (int t = 0; t < NT; t++) begin
      a = t << TS;
      d = 0;
      lat += 1;
      for (int v = 0; v <= MD; v++) begin
        w = node_mem[a];
        if (w[NW-1]) begin
          lat += 2;
          c = int'(w[CW-1:0]);
          if (c < NC && votes[c] < 255) votes[c]++;
          break;
        end
        lat += 3;
        fidx = int'(w[NW-2 -: FAW]);
        thr  = int'(w[NAW+7 -: 8]);
        ch   = int'(w[NAW-1:0]);
        a = (int'(feat_mem[fidx]) <= thr) ? ch : (ch + 1) % (1 << NAW);
        d++;
        if (d == MD) begin
          exp_err = 1;
          break;
        end
      end
    end
    exp_res = 0;
    exp_votes = 0;
    for (int k = 0; k < NC; k++) begin
      if (votes[k] > exp_votes) begin
        exp_res = k;
        exp_votes = votes[k];
      end
      exp_hist[k*8 +: 8] = 8'(votes[k]);
    end
    exp_lat = lat + NC + 1;
  endtask

  // Compare process: cycle 0 is the cycle start is high
  initial forever begin
    @(negedge clk);
    if (active) begin
      check("busy", busy, (cyc >= 1 && cyc < exp_lat));
      check("done", done, cyc == exp_lat);
      if (done && done_cyc < 0) done_cyc = cyc;
      if (cyc == probe_cyc) check("feat_addr", feat_rd_addr, probe_exp);
      if (cyc >= exp_lat) begin
        check("result", result, exp_res);
        check("result_votes", result_votes, exp_votes);
        check("depth_err", depth_err, exp_err);
`ifdef FOREST_EVAL_HIST_EN
        check("vote_hist", vote_hist, exp_hist);
`endif
      end
      cyc++;
    end
  end

  task automatic run(input int again);
    model();
    @(posedge clk);
    #1 start = 1'b1;
    cyc = 0;
    done_cyc = -1;
    active = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k < exp_lat + 3; k++) begin
      if (k == again) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
    end
    active = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int seen;
    for (int a = 0; a < (1 << NAW); a++) node_mem[a] = '0;
    for (int a = 0; a < (1 << FAW); a++) feat_mem[a] = '0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_votes", result_votes, 0);
    check("rst_depth_err", depth_err, 0);
    check("rst_node_addr", node_rd_addr, 0);
    check("rst_feat_addr", feat_rd_addr, 0);
    @(negedge clk) rst = 1'b0;

    roots(3, 3, 3, 3);
    run(0);
    check("t1_lat", done_cyc, 18);
    check("t1_res", result, 3);
    check("t1_votes", result_votes, 4);

    roots(0, 2, 2, 0);
    put_int(0, 5, 100, 'h010);
    put_leaf('h010, 0);
    put_leaf('h011, 2);
    feat_mem[5] = 8'd101;
    probe_cyc = 3;
    probe_exp = 5;
    run(0);
    check("t2_lat", done_cyc, 21);
    check("t2_res", result, 2);
    check("t2_votes", result_votes, 3);

    feat_mem[5] = 8'd100;
    run(0);
    probe_cyc = -1;
    check("t2b_res", result, 0);
    check("t2b_votes", result_votes, 2);

    roots(1, 2, 1, 2);
    run(0);
    check("tie_res", result, 1);
    check("tie_votes", result_votes, 2);

    roots(0, 3, 3, 3);
    run(0);
    check("maj_res", result, 3);
    check("maj_votes", result_votes, 3);

    roots(0, 0, 1, 1);
    put_int(1 << TS, 0, 255, 1 << TS);
    run(0);
    check("abort_lat", done_cyc, 61);
    check("abort_err", depth_err, 1);
    check("abort_res", result, 1);
    check("abort_votes", result_votes, 2);

    roots(5, 5, 5, 5);
    run(0);
    check("none_res", result, 0);
    check("none_votes", result_votes, 0);
    check("none_err", depth_err, 0);

    roots(1, 2, 1, 2);
    run(6);
    check("restart_lat", done_cyc, 18);

    roots(1, 1, 1, 2);
    run(0);
    check("hist_res", result, 1);
    check("hist_votes", result_votes, 3);
`ifdef FOREST_EVAL_HIST_EN
    check("hist_lit", vote_hist, 32'h00010300);
`endif

    roots(3, 3, 3, 3);
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_result", result, 0);
    check("arst_votes", result_votes, 0);
`ifdef FOREST_EVAL_HIST_EN
    check("arst_hist", vote_hist, 0);
`endif
    @(posedge clk);
    #1 rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      seen += int'(done) + int'(busy);
    end
    check("arst_idle", seen, 0);

    roots(2, 2, 2, 2);
    run(0);
    check("recover_res", result, 2);
    check("recover_votes", result_votes, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
